vector_mem_stage: RTL and testbench
===================================

VECTOR_MEM_STAGE -- requirements
Module: vector_mem_stage

Interface
REQ-001 Parameter WORDS, default 8, 32-bit beats per 256-bit vector.
REQ-002 Parameter ADDR_W, default 32, byte-address width to data RAM.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assert, active-low, synchronous release.
REQ-005 MemWriteM  in  1  store request from EX/MEM register.
REQ-006 MemtoRegM  in  1  load request from EX/MEM register.
REQ-007 ALUResultM  in  256  bits [ADDR_W-1:0] = base byte address.
REQ-008 WriteDataM  in  256  store vector; word k = bits [32k+31:32k].
REQ-009 StallM  out  1  freeze upstream stages and EX/MEM register.
REQ-010 ReadDataM  out  256  assembled load vector.
REQ-011 ReadValidM  out  1  one-cycle pulse: ReadDataM holds a new load result.
REQ-012 mem_addr  out  ADDR_W  RAM word byte address.
REQ-013 mem_wdata  out  32  RAM write data.
REQ-014 mem_we  out  1  RAM write strobe.
REQ-015 mem_re  out  1  RAM read strobe.
REQ-016 mem_rdata  in  32  RAM read data, valid exactly one cycle after mem_re.

Function
REQ-017 FSM states SHALL be IDLE, WRITE, READ, TAIL.
REQ-018 In IDLE, request = MemWriteM | MemtoRegM; at cycle T with request, base (low 2 bits forced 0) and WriteDataM SHALL be captured; next state WRITE if MemWriteM else READ.
REQ-019 MemWriteM and MemtoRegM both high SHALL be a store; the load is discarded.
REQ-020 Beat counter k runs 0..WORDS-1; mem_addr = base + 4k, wrapping modulo 2^ADDR_W.
REQ-021 WRITE: cycles T+1..T+WORDS, mem_we=1, mem_wdata = word k; after last beat go IDLE.
REQ-022 READ: cycles T+1..T+WORDS, mem_re=1; mem_rdata in cycle T+2+k SHALL be stored to lane k; after last beat go TAIL.
REQ-023 TAIL (cycle T+WORDS+1): capture lane WORDS-1, no strobes, go IDLE.
REQ-024 ReadDataM SHALL update only at end of TAIL; ReadValidM high in cycle T+WORDS+2 only; ReadDataM held until next load completes.
REQ-025 StallM SHALL be combinational: 1 in IDLE with request, in WRITE except last beat, in READ; 0 in TAIL, last WRITE beat, and idle without request.
REQ-026 Store: StallM high T..T+WORDS-1; load: StallM high T..T+WORDS.
REQ-027 mem_we and mem_re SHALL never be high together; both 0 in IDLE and TAIL.
REQ-028 A request visible in the cycle after returning to IDLE SHALL be accepted with no bubble.
REQ-029 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, k=0, mem_we=mem_re=0, StallM=0, ReadValidM=0, ReadDataM=0, mem_addr=0, mem_wdata=0.
REQ-031 Reset mid-operation SHALL abandon the access; partial load lanes SHALL NOT reach ReadDataM; no ReadValidM pulse.

Structure
REQ-032 Package vmem_pkg SHALL hold WORD_W=32, VEC_W=256, default WORDS, and the state enum type.
REQ-033 Single module; no sub-module; lane assembly register and beat counter inline.

Verification
REQ-034 Store base 0x100, words 0x11111111..0x88888888 -> mem_we beats addr 0x100..0x11C, StallM high 8 cycles, low on beat 8.
REQ-035 Load 0x100 after REQ-034 with RAM model -> ReadValidM one pulse at T+10, ReadDataM = 0x88888888_..._11111111, StallM high 9 cycles.
REQ-036 Base 0x103 with both MemWriteM and MemtoRegM -> store only, addresses 0x100..0x11C, no mem_re, no ReadValidM.
REQ-037 Base 0xFFFFFFF8 load -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0..0x14.
REQ-038 rst_n low at READ beat 4 -> strobes and StallM drop same cycle, ReadDataM=0, no ReadValidM; next load completes normally.
REQ-039 Store then load back-to-back -> load accepted cycle after last store beat, no idle gap.

Source files
------------

// File: rtl/vmem_pkg.sv
// Shared widths, default geometry and FSM state type for the vector memory stage.
package vmem_pkg;

    localparam int WORD_W        = 32;
    localparam int VEC_W         = 256;
    localparam int WORDS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        TAIL  = 2'd3
    } state_t;

endpackage

// File: rtl/vector_mem_stage.sv
// MEM stage that serialises a 256-bit vector load/store into WORDS single-word
// RAM beats, stalling the upstream pipeline while the burst is in flight.
module vector_mem_stage
    import vmem_pkg::*;
#(
    parameter int WORDS  = WORDS_DEFAULT,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemWriteM,
    input  logic              MemtoRegM,
    input  logic [VEC_W-1:0]  ALUResultM,
    input  logic [VEC_W-1:0]  WriteDataM,
    output logic              StallM,
    output logic [VEC_W-1:0]  ReadDataM,
    output logic              ReadValidM,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] LAST = KW'(WORDS - 1);

    state_t            state;
    logic [KW-1:0]     beat;
    logic [VEC_W-1:0]  vec_buf;
    logic              request;
    logic              last_beat;
    logic [ADDR_W-1:0] base_aligned;
    logic              unused_addr_bits;

    assign request          = MemWriteM | MemtoRegM;
    assign last_beat        = (beat == LAST);
    assign base_aligned     = {ALUResultM[ADDR_W-1:2], 2'b00};
    assign unused_addr_bits = ^{ALUResultM[VEC_W-1:ADDR_W], ALUResultM[1:0]};

    // Gated by rst_n so the upstream freeze releases the instant reset asserts.
    always_comb begin
        StallM = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE:    StallM = request;
                WRITE:   StallM = !last_beat;
                READ:    StallM = 1'b1;
                default: StallM = 1'b0;
            endcase
        end
    end

    // vec_buf shifts right one word per beat: stores drain word 0 first,
    // loads enter at the top so lane 0 ends up at the bottom after WORDS shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat       <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            vec_buf    <= '0;
            ReadDataM  <= '0;
            ReadValidM <= 1'b0;
        end else begin
            ReadValidM <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        state     <= MemWriteM ? WRITE : READ;
                        beat      <= '0;
                        mem_addr  <= base_aligned;
                        mem_we    <= MemWriteM;
                        mem_re    <= !MemWriteM;
                        mem_wdata <= WriteDataM[WORD_W-1:0];
                        vec_buf   <= WriteDataM >> WORD_W;
                    end
                end
                WRITE: begin
                    if (last_beat) begin
                        state  <= IDLE;
                        beat   <= '0;
                        mem_we <= 1'b0;
                    end else begin
                        beat      <= beat + 1'b1;
                        mem_addr  <= mem_addr + ADDR_W'(4);
                        mem_wdata <= vec_buf[WORD_W-1:0];
                        vec_buf   <= vec_buf >> WORD_W;
                    end
                end
                READ: begin
                    // Read data trails the strobe by one cycle, so beat 0 has nothing to catch.
                    if (beat != '0)
                        vec_buf <= {mem_rdata, vec_buf[VEC_W-1:WORD_W]};
                    if (last_beat) begin
                        state  <= TAIL;
                        beat   <= '0;
                        mem_re <= 1'b0;
                    end else begin
                        beat     <= beat + 1'b1;
                        mem_addr <= mem_addr + ADDR_W'(4);
                    end
                end
                TAIL: begin
                    ReadDataM  <= {mem_rdata, vec_buf[VEC_W-1:WORD_W]};
                    ReadValidM <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_mem_stage.sv
// Directed bench for vector_mem_stage with a one-cycle-latency RAM model.
module tb_vector_mem_stage;
    import vmem_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         MemWriteM = 1'b0;
    logic         MemtoRegM = 1'b0;
    logic [255:0] ALUResultM = '0;
    logic [255:0] WriteDataM = '0;
    logic         StallM;
    logic [255:0] ReadDataM;
    logic         ReadValidM;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_we;
    logic         mem_re;
    logic [31:0]  mem_rdata = '0;

    logic [31:0]  ram [logic [31:0]];
    int total = 0;
    int bad = 0;

    vector_mem_stage #(.WORDS(8), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .StallM(StallM), .ReadDataM(ReadDataM), .ReadValidM(ReadValidM),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Unwritten locations return a recognisable address-derived pattern.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] = mem_wdata;
        if (mem_re) mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : (mem_addr ^ 32'h5A5A5A5A);
    end

    function automatic logic [255:0] seq_vec(input logic [31:0] start, input logic [31:0] step);
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = start + step * k;
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        MemWriteM = 1'b1; ALUResultM = 256'h100; WriteDataM = '1;
        tick(); #1;
        total++; if (StallM !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%b want=0", StallM); end
        total++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin bad++; $display("[TB] FAIL reset_strobes got=%b%b want=00", mem_we, mem_re); end
        total++; if (ReadValidM !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", ReadValidM); end
        total++; if (ReadDataM !== '0) begin bad++; $display("[TB] FAIL reset_rdata got=%h want=0", ReadDataM); end
        total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_addr_wdata got=%h/%h want=0/0", mem_addr, mem_wdata); end
        MemWriteM = 1'b0; WriteDataM = '0;
        tick(); rst_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_store();
        logic [31:0] exp_addr;
        tick();
        MemWriteM = 1'b1; ALUResultM = 256'h100;
        WriteDataM = seq_vec(32'h11111111, 32'h11111111);
        #1;
        total++; if (StallM !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("[TB] FAIL store_accept stall/we got=%b/%b want=1/0", StallM, mem_we); end
        for (int c = 1; c <= 8; c++) begin
            tick(); #1;
            exp_addr = 32'h100 + 32'(4 * (c - 1));
            total++; if (mem_we !== 1'b1 || mem_re !== 1'b0) begin bad++; $display("[TB] FAIL store_strobe c=%0d we/re got=%b/%b want=1/0", c, mem_we, mem_re); end
            total++; if (mem_addr !== exp_addr) begin bad++; $display("[TB] FAIL store_addr c=%0d got=%h want=%h", c, mem_addr, exp_addr); end
            total++; if (mem_wdata !== 32'h11111111 * c) begin bad++; $display("[TB] FAIL store_wdata c=%0d got=%h want=%h", c, mem_wdata, 32'h11111111 * c); end
            total++; if (StallM !== (c < 8)) begin bad++; $display("[TB] FAIL store_stall c=%0d got=%b want=%b", c, StallM, c < 8); end
        end
        tick(); MemWriteM = 1'b0; #1;
        total++; if (mem_we !== 1'b0 || StallM !== 1'b0) begin bad++; $display("[TB] FAIL store_done we/stall got=%b/%b want=0/0", mem_we, StallM); end
    endtask

    task automatic test_load();
        logic [31:0] exp_addr;
        tick();
        MemtoRegM = 1'b1; ALUResultM = 256'h100; #1;
        total++; if (StallM !== 1'b1) begin bad++; $display("[TB] FAIL load_accept_stall got=%b want=1", StallM); end
        for (int c = 1; c <= 8; c++) begin
            tick(); #1;
            exp_addr = 32'h100 + 32'(4 * (c - 1));
            total++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("[TB] FAIL load_strobe c=%0d re/we got=%b/%b want=1/0", c, mem_re, mem_we); end
            total++; if (mem_addr !== exp_addr) begin bad++; $display("[TB] FAIL load_addr c=%0d got=%h want=%h", c, mem_addr, exp_addr); end
            total++; if (StallM !== 1'b1 || ReadValidM !== 1'b0) begin bad++; $display("[TB] FAIL load_stall_valid c=%0d got=%b/%b want=1/0", c, StallM, ReadValidM); end
        end
        tick(); MemtoRegM = 1'b0; #1;
        total++; if (mem_re !== 1'b0 || StallM !== 1'b0 || ReadValidM !== 1'b0) begin bad++; $display("[TB] FAIL load_tail re/stall/valid got=%b%b%b want=000", mem_re, StallM, ReadValidM); end
        tick(); #1;
        total++; if (ReadValidM !== 1'b1) begin bad++; $display("[TB] FAIL load_valid got=%b want=1", ReadValidM); end
        total++; if (ReadDataM !== 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111) begin bad++; $display("[TB] FAIL load_data got=%h", ReadDataM); end
        tick(); #1;
        total++; if (ReadValidM !== 1'b0) begin bad++; $display("[TB] FAIL load_valid_pulse got=%b want=0", ReadValidM); end
        total++; if (ReadDataM[31:0] !== 32'h11111111) begin bad++; $display("[TB] FAIL load_hold got=%h want=11111111", ReadDataM[31:0]); end
    endtask

    task automatic test_both_requests();
        logic [31:0] exp_addr;
        int re_seen = 0;
        int valid_seen = 0;
        tick();
        MemWriteM = 1'b1; MemtoRegM = 1'b1; ALUResultM = 256'h103;
        WriteDataM = seq_vec(32'hA0000000, 32'h1);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 9) begin MemWriteM = 1'b0; MemtoRegM = 1'b0; end
            #1;
            if (mem_re) re_seen++;
            if (ReadValidM) valid_seen++;
            if (c <= 8) begin
                exp_addr = 32'h100 + 32'(4 * (c - 1));
                total++; if (mem_we !== 1'b1 || mem_addr !== exp_addr) begin bad++; $display("[TB] FAIL both_store c=%0d we/addr got=%b/%h want=1/%h", c, mem_we, mem_addr, exp_addr); end
                total++; if (mem_wdata !== 32'hA0000000 + c - 1) begin bad++; $display("[TB] FAIL both_wdata c=%0d got=%h want=%h", c, mem_wdata, 32'hA0000000 + c - 1); end
            end
        end
        total++; if (re_seen != 0 || valid_seen != 0) begin bad++; $display("[TB] FAIL both_no_load re=%0d valid=%0d want=0/0", re_seen, valid_seen); end
        total++; if (ReadDataM[255:224] !== 32'h88888888) begin bad++; $display("[TB] FAIL both_hold got=%h want=88888888", ReadDataM[255:224]); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [8] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        logic [255:0] exp_vec;
        for (int k = 0; k < 8; k++) exp_vec[32*k +: 32] = exp_addr[k] ^ 32'h5A5A5A5A;
        tick();
        MemtoRegM = 1'b1; ALUResultM = 256'hFFFFFFF8;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 9) MemtoRegM = 1'b0;
            #1;
            if (c <= 8) begin
                total++; if (mem_re !== 1'b1 || mem_addr !== exp_addr[c-1]) begin bad++; $display("[TB] FAIL wrap_addr c=%0d re/addr got=%b/%h want=1/%h", c, mem_re, mem_addr, exp_addr[c-1]); end
            end
        end
        total++; if (ReadValidM !== 1'b1 || ReadDataM !== exp_vec) begin bad++; $display("[TB] FAIL wrap_data valid=%b got=%h want=%h", ReadValidM, ReadDataM, exp_vec); end
    endtask

    task automatic test_reset_mid();
        int valid_seen = 0;
        logic [255:0] exp_vec;
        for (int k = 0; k < 8; k++) exp_vec[32*k +: 32] = (32'h200 + 32'(4 * k)) ^ 32'h5A5A5A5A;
        tick();
        MemtoRegM = 1'b1; ALUResultM = 256'h200;
        for (int c = 1; c <= 5; c++) tick();
        #1;
        total++; if (mem_re !== 1'b1 || mem_addr !== 32'h210) begin bad++; $display("[TB] FAIL rstmid_beat4 re/addr got=%b/%h want=1/00000210", mem_re, mem_addr); end
        rst_n = 1'b0; MemtoRegM = 1'b0; #1;
        total++; if (mem_re !== 1'b0 || mem_we !== 1'b0 || StallM !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_drop re/we/stall got=%b%b%b want=000", mem_re, mem_we, StallM); end
        total++; if (ReadDataM !== '0 || ReadValidM !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_rdata got=%h valid=%b want=0/0", ReadDataM, ReadValidM); end
        tick(); rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin tick(); #1; if (ReadValidM) valid_seen++; end
        total++; if (valid_seen != 0 || ReadDataM !== '0) begin bad++; $display("[TB] FAIL rstmid_no_result valid=%0d data=%h want=0/0", valid_seen, ReadDataM); end
        tick();
        MemtoRegM = 1'b1; ALUResultM = 256'h200;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 9) MemtoRegM = 1'b0;
            #1;
            if (ReadValidM) valid_seen++;
        end
        total++; if (ReadValidM !== 1'b1 || valid_seen != 1 || ReadDataM !== exp_vec) begin bad++; $display("[TB] FAIL rstmid_reload valid=%b pulses=%0d got=%h want=%h", ReadValidM, valid_seen, ReadDataM, exp_vec); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] store_vec;
        store_vec = seq_vec(32'hC0000000, 32'h01010101);
        tick();
        MemWriteM = 1'b1; ALUResultM = 256'h300; WriteDataM = store_vec;
        for (int c = 1; c <= 8; c++) tick();
        #1;
        total++; if (StallM !== 1'b0 || mem_we !== 1'b1) begin bad++; $display("[TB] FAIL b2b_last_beat stall/we got=%b/%b want=0/1", StallM, mem_we); end
        tick();
        MemWriteM = 1'b0; MemtoRegM = 1'b1; ALUResultM = 256'h300; #1;
        total++; if (StallM !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("[TB] FAIL b2b_accept stall/we got=%b/%b want=1/0", StallM, mem_we); end
        tick(); #1;
        total++; if (mem_re !== 1'b1 || mem_addr !== 32'h300) begin bad++; $display("[TB] FAIL b2b_first_read re/addr got=%b/%h want=1/00000300", mem_re, mem_addr); end
        for (int c = 2; c <= 10; c++) begin
            tick();
            if (c == 9) MemtoRegM = 1'b0;
        end
        #1;
        total++; if (ReadValidM !== 1'b1 || ReadDataM !== store_vec) begin bad++; $display("[TB] FAIL b2b_data valid=%b got=%h want=%h", ReadValidM, ReadDataM, store_vec); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_both_requests();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
